// File: rtl/adc_spi_ctrl_if.sv
// Scanner-side handshake bundle for the slider ADC SPI engine.
// The scanner (master) offers a channel and a start request; the engine
// (slave) returns the conversion, the channel it belongs to and a level
// completion flag.
interface adc_spi_ctrl_if;
    logic [2:0]  channel;
    logic        strt_cnv;
    logic [11:0] result;
    logic [2:0]  last_chnl;
    logic        cnv_complete;

    modport master (
        output channel,
        output strt_cnv,
        input  result,
        input  last_chnl,
        input  cnv_complete
    );

    modport slave (
        input  channel,
        input  strt_cnv,
        output result,
        output last_chnl,
        output cnv_complete
    );
endinterface

// File: rtl/adc_spi_ctrl.sv
// SPI transaction engine for the 8-channel 12-bit slider ADC (SPI mode 3).
// One accepted start runs one 16-bit frame: FRONT porch, 16 SCLK periods,
// BACK porch. The ADC pipelines its data, so the word shifted in during a
// frame is the conversion for the address sent in the previous frame.
// Every output comes straight from a flop.
module adc_spi_ctrl #(
    parameter int SCLK_DIV = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    adc_spi_ctrl_if.slave scan,
    input  logic          MISO,
    output logic          MOSI,
    output logic          SCLK,
    output logic          SS_n
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(SCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRONT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_BACK  = 2'd3
    } state_t;

    state_t           state_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [15:0]      tx_shift_r;
    // Only the low 12 received bits matter; the ADC's four leading zeros
    // simply fall off the top of this register.
    logic [11:0]      rx_shift_r;
    logic [2:0]       addr_r;
    logic [11:0]      result_r;
    logic [2:0]       last_chnl_r;
    logic             cnv_complete_r;
    logic             mosi_r;
    logic             sclk_r;
    logic             ss_n_r;
    logic [15:0]      tx_load_s;

    // Command word: two zero bits, 3-bit address, eleven don't-care zeros.
    assign tx_load_s = {2'b00, scan.channel, 11'b000_0000_0000};

    // Frame sequencer: state, counters, shift registers and all pin/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            div_cnt_r      <= CNT_ZERO;
            bit_cnt_r      <= 4'd0;
            tx_shift_r     <= 16'h0000;
            rx_shift_r     <= 12'h000;
            addr_r         <= 3'b000;
            result_r       <= 12'h000;
            last_chnl_r    <= 3'b000;
            cnv_complete_r <= 1'b1;
            mosi_r         <= 1'b0;
            sclk_r         <= 1'b1;
            ss_n_r         <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (scan.strt_cnv) begin
                        addr_r         <= scan.channel;
                        tx_shift_r     <= tx_load_s;
                        rx_shift_r     <= 12'h000;
                        mosi_r         <= tx_load_s[15];
                        ss_n_r         <= 1'b0;
                        cnv_complete_r <= 1'b0;
                        div_cnt_r      <= CNT_ZERO;
                        bit_cnt_r      <= 4'd0;
                        state_r        <= ST_FRONT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FRONT: begin
                    // MSB is already on MOSI; hold it through the porch.
                    mosi_r <= tx_shift_r[15];
                    if (div_cnt_r == HALF_M1) begin
                        div_cnt_r <= CNT_ZERO;
                        sclk_r    <= 1'b0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r == DIV_M1) begin
                        div_cnt_r <= CNT_ZERO;
                        if (bit_cnt_r == 4'd15) begin
                            // Leave SCLK high and close with the back porch.
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_BACK;
                        end else begin
                            // Falling edge of periods 2..16: present next bit.
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                            sclk_r     <= 1'b0;
                            tx_shift_r <= {tx_shift_r[14:0], 1'b0};
                            mosi_r     <= tx_shift_r[14];
                        end
                    end else if (div_cnt_r == HALF_M1) begin
                        // Rising edge: MISO has had half a period to settle.
                        div_cnt_r  <= div_cnt_r + CNT_ONE;
                        sclk_r     <= 1'b1;
                        rx_shift_r <= {rx_shift_r[10:0], MISO};
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                    end
                end
                ST_BACK: begin
                    if (div_cnt_r == HALF_M1) begin
                        div_cnt_r      <= CNT_ZERO;
                        ss_n_r         <= 1'b1;
                        mosi_r         <= 1'b0;
                        result_r       <= rx_shift_r;
                        last_chnl_r    <= addr_r;
                        cnv_complete_r <= 1'b1;
                        state_r        <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    div_cnt_r      <= CNT_ZERO;
                    bit_cnt_r      <= 4'd0;
                    mosi_r         <= 1'b0;
                    sclk_r         <= 1'b1;
                    ss_n_r         <= 1'b1;
                    cnv_complete_r <= 1'b1;
                end
            endcase
        end
    end

    assign scan.result       = result_r;
    assign scan.last_chnl    = last_chnl_r;
    assign scan.cnv_complete = cnv_complete_r;
    assign MOSI              = mosi_r;
    assign SCLK              = sclk_r;
    assign SS_n              = ss_n_r;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Self-checking bench for adc_spi_ctrl: a behavioural ADC on the SPI pins,
// a driver that queues the expected result for each issued frame, and a
// monitor that checks every completed frame against the queue.
module tb_adc_spi_ctrl;

    localparam int SCLK_DIV  = 32;
    localparam int FRAME_CLK = 17 * SCLK_DIV;
    localparam int LIMIT     = 3 * FRAME_CLK;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MISO  = 1'b0;
    logic MOSI;
    logic SCLK;
    logic SS_n;

    adc_spi_ctrl_if bus ();

    adc_spi_ctrl #(.SCLK_DIV(SCLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (bus),
        .MISO  (MISO),
        .MOSI  (MOSI),
        .SCLK  (SCLK),
        .SS_n  (SS_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  chan;
        logic [11:0] res;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] payload_q[$];
    int         gaps[$];
    int         cc_runs[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] model_prev = 3'd0;
    int         frames_started = 0;
    int         sclk_total = 0;
    int         frame_falls = 0;
    int         idle_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: frame returns {previous accepted channel, payload}.
    task automatic issue(input logic [2:0] ch, input logic [8:0] pl);
        exp_t e;
        e.chan = ch;
        e.res  = {model_prev, pl};
        exp_q.push_back(e);
        payload_q.push_back(pl);
        model_prev = ch;
    endtask

    // ---------------- behavioural ADC ----------------
    logic [15:0] adc_tx  = 16'h0;
    logic [15:0] adc_cmd = 16'h0;
    logic [2:0]  adc_prev = 3'd0;
    int          adc_rises = 0;

    initial forever begin
        @(negedge SS_n);
        if (rst_n) begin
            if (payload_q.size() > 0) adc_tx = {4'h0, adc_prev, payload_q.pop_front()};
            else adc_tx = 16'h0;
            adc_rises = 0;
        end
    end

    initial forever begin
        @(negedge SCLK);
        if (rst_n && !SS_n) begin
            MISO   = adc_tx[15];
            adc_tx = {adc_tx[14:0], 1'b0};
        end
    end

    initial forever begin
        @(posedge SCLK);
        if (rst_n && !SS_n) begin
            adc_cmd = {adc_cmd[14:0], MOSI};
            adc_rises++;
        end
    end

    initial forever begin
        @(posedge SS_n);
        if (rst_n && adc_rises == 16) adc_prev = adc_cmd[13:11];
    end

    initial forever begin
        @(negedge rst_n);
        adc_prev = 3'd0;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic prev_cc, prev_ss, prev_sclk, prev_mosi;
        int   ss_low, rises, mosi_bad, ss_high_run, cc_run;
        exp_t e;
        prev_cc = 1'b1; prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
        ss_low = 0; rises = 0; mosi_bad = 0; ss_high_run = 0; cc_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cc = 1'b1; prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
                ss_low = 0; rises = 0; mosi_bad = 0; ss_high_run = 0; cc_run = 0;
                frame_falls = 0;
            end else begin
                if (!SS_n) ss_low++;
                if (prev_sclk && !SCLK) begin
                    frame_falls++;
                    sclk_total++;
                end
                if (!prev_sclk && SCLK) rises++;
                if (SS_n && prev_ss && (SCLK !== prev_sclk)) idle_bad++;
                if ((MOSI !== prev_mosi) && !(prev_sclk && !SCLK) && (SS_n === prev_ss)) mosi_bad++;
                if (SS_n) ss_high_run++;
                if (prev_ss && !SS_n) begin
                    frames_started++;
                    gaps.push_back(ss_high_run);
                    ss_high_run = 0;
                end
                if (bus.cnv_complete) cc_run++;
                if (prev_cc && !bus.cnv_complete) begin
                    cc_runs.push_back(cc_run);
                    cc_run = 0;
                end
                if (!prev_cc && bus.cnv_complete) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {20'h0, bus.result}, {20'h0, e.res});
                        check("last_chnl", {29'h0, bus.last_chnl}, {29'h0, e.chan});
                        check("mosi_command", {16'h0, adc_cmd}, {16'h0, 2'b00, e.chan, 11'h000});
                        check("frame_length", ss_low, FRAME_CLK);
                        check("sclk_falls", frame_falls, 16);
                        check("sclk_rises", rises, 16);
                        check("mosi_stable", mosi_bad, 0);
                    end
                    ss_low = 0; rises = 0; mosi_bad = 0; frame_falls = 0;
                end
                prev_cc = bus.cnv_complete; prev_ss = SS_n; prev_sclk = SCLK; prev_mosi = MOSI;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_done(input string name);
        int n = 0;
        while (bus.cnv_complete !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_start(input int target);
        int n = 0;
        while (frames_started < target && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input logic [2:0] ch, input logic [8:0] pl);
        wait_done("idle_timeout");
        @(negedge clk);
        bus.channel  = ch;
        bus.strt_cnv = 1'b1;
        issue(ch, pl);
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        bus.channel  = 3'($urandom);
        wait_done("frame_timeout");
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        int         f0;
        int         t0;
        int         n;
        logic [2:0] ch;
        bus.channel  = 3'd0;
        bus.strt_cnv = 1'b0;
        rst_n        = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ss_n", {31'h0, SS_n}, 32'd1);
        check("rst_sclk", {31'h0, SCLK}, 32'd1);
        check("rst_mosi", {31'h0, MOSI}, 32'd0);
        check("rst_cnv_complete", {31'h0, bus.cnv_complete}, 32'd1);
        check("rst_result", {20'h0, bus.result}, 32'd0);
        check("rst_last_chnl", {29'h0, bus.last_chnl}, 32'd0);
        rst_n = 1'b1;
        t0 = sclk_total;
        f0 = frames_started;
        repeat (1000) @(negedge clk);
        check("idle_sclk_edges", sclk_total - t0, 32'd0);
        check("idle_frames", frames_started - f0, 32'd0);

        // Directed: channel 5 twice, second frame returns 0x0ABC.
        run_frame(3'b101, 9'($urandom));
        run_frame(3'b101, 9'h0BC);
        check("directed_abc", {20'h0, bus.result}, 32'h0000_0ABC);

        // Pipelined addressing 0, 1, 7.
        run_frame(3'd0, 9'($urandom));
        run_frame(3'd1, 9'($urandom));
        run_frame(3'd7, 9'($urandom));

        // Randomized frames.
        for (int i = 0; i < 8; i++) run_frame(3'($urandom), 9'($urandom));

        // Busy-ignore: a second start mid-frame with a new channel.
        wait_done("idle_timeout");
        @(negedge clk);
        bus.channel  = 3'd6;
        bus.strt_cnv = 1'b1;
        issue(3'd6, 9'($urandom));
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        repeat (98) @(negedge clk);
        f0 = frames_started;
        bus.channel  = 3'b010;
        bus.strt_cnv = 1'b1;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        wait_done("busy_timeout");
        repeat (100) @(negedge clk);
        check("busy_no_second_frame", frames_started - f0, 32'd0);

        // Back-to-back with strt_cnv held high.
        gaps.delete();
        cc_runs.delete();
        f0 = frames_started;
        @(negedge clk);
        ch = 3'($urandom);
        bus.channel  = ch;
        bus.strt_cnv = 1'b1;
        issue(ch, 9'($urandom));
        for (int i = 1; i <= 6; i++) begin
            wait_start(f0 + i);
            if (i < 6) begin
                ch = 3'($urandom);
                bus.channel = ch;
                issue(ch, 9'($urandom));
            end
        end
        bus.strt_cnv = 1'b0;
        wait_done("b2b_timeout");
        check("b2b_gap_count", gaps.size(), 32'd6);
        check("b2b_cc_count", cc_runs.size(), 32'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < gaps.size()) check("b2b_ss_high_clk", gaps[i], 32'd1);
            if (i < cc_runs.size()) check("b2b_cc_high_clk", cc_runs[i], 32'd1);
        end

        // Reset in the middle of bit 8.
        wait_done("idle_timeout");
        @(negedge clk);
        bus.channel  = 3'd3;
        bus.strt_cnv = 1'b1;
        issue(3'd3, 9'($urandom));
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        n = 0;
        while (frame_falls < 8 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("bit8_timeout", 32'd0, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ss_n", {31'h0, SS_n}, 32'd1);
        check("midrst_sclk", {31'h0, SCLK}, 32'd1);
        check("midrst_mosi", {31'h0, MOSI}, 32'd0);
        check("midrst_cnv_complete", {31'h0, bus.cnv_complete}, 32'd1);
        check("midrst_result", {20'h0, bus.result}, 32'd0);
        exp_q.delete();
        payload_q.delete();
        model_prev = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_result_kept", {20'h0, bus.result}, 32'd0);
        run_frame(3'($urandom), 9'($urandom));
        run_frame(3'($urandom), 9'($urandom));

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("sclk_idle_toggles", idle_bad, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
